// File: rtl/wb_pwm_capture.sv
`timescale 1ns/1ps
// wb_pwm_capture: multi-channel PWM input capture with a Wishbone B4 pipelined
// read port. Each channel measures period and high time of its input in
// clock cycles and holds the latest result until it is replaced.
// Optional build macro PWM_CAPTURE_IRQ_EN adds an irq output (registered OR
// of every channel's valid flag).
module wb_pwm_capture #(
  parameter int BIT_NUM     = 8,
  parameter int CHANNEL_NUM = 3
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [3:0]             wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_stall_o,
  input  logic [CHANNEL_NUM-1:0] pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam logic [BIT_NUM-1:0] MAX = '1;
  localparam logic [BIT_NUM-1:0] ONE = BIT_NUM'(1);

  logic                   req;
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic [31:0]            rdata;
  logic [CHANNEL_NUM-1:0] valid_v;
  logic [CHANNEL_NUM-1:0] ovf_v;
  logic [BIT_NUM-1:0]     period_v [CHANNEL_NUM];
  logic [BIT_NUM-1:0]     high_v   [CHANNEL_NUM];

  // write data is never stored; fold it so it has a reader
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;

  assign req        = wb_cyc_i & wb_stb_i;
  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    logic               sync1_q, sync2_q, dly_q;
    logic               armed_q, armed_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [BIT_NUM-1:0] pcnt_q, pcnt_d;
    logic [BIT_NUM-1:0] hcnt_q, hcnt_d;
    logic [BIT_NUM-1:0] period_q, period_d;
    logic [BIT_NUM-1:0] high_q, high_d;
    logic               s, rise, clr;

    assign s    = sync2_q;
    assign rise = sync2_q & ~dly_q;
    // period-word read of this channel, sampled this cycle
    assign clr  = req & ~wb_we_i & wb_adr_i[0] & (wb_adr_i[3:1] == 3'(c));

    assign valid_v[c]  = valid_q;
    assign ovf_v[c]    = ovf_q;
    assign period_v[c] = period_q;
    assign high_v[c]   = high_q;

    // measurement next state; a latch overrides a same-cycle read-clear
    always_comb begin
      pcnt_d   = (pcnt_q == MAX) ? pcnt_q : pcnt_q + ONE;
      hcnt_d   = (s && hcnt_q != MAX) ? hcnt_q + ONE : hcnt_q;
      armed_d  = armed_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      period_d = period_q;
      high_d   = high_q;
      if (clr) begin
        valid_d = 1'b0;
        ovf_d   = 1'b0;
      end
      if (rise) begin
        // the rise cycle itself is the first counted cycle of the new period
        pcnt_d  = ONE;
        hcnt_d  = ONE;
        armed_d = 1'b1;
        if (armed_q) begin
          period_d = pcnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          ovf_d    = 1'b0;
        end
      end else if (pcnt_q == MAX) begin
        period_d = MAX;
        high_d   = hcnt_q;
        valid_d  = 1'b1;
        ovf_d    = 1'b1;
        armed_d  = 1'b1;
        pcnt_d   = ONE;
        hcnt_d   = s ? ONE : '0;
      end
    end

    // synchronizer, edge history and measurement registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        dly_q    <= 1'b0;
        armed_q  <= 1'b0;
        valid_q  <= 1'b0;
        ovf_q    <= 1'b0;
        pcnt_q   <= '0;
        hcnt_q   <= '0;
        period_q <= '0;
        high_q   <= '0;
      end else begin
        sync1_q  <= pwm_in[c];
        sync2_q  <= sync1_q;
        dly_q    <= sync2_q;
        armed_q  <= armed_d;
        valid_q  <= valid_d;
        ovf_q    <= ovf_d;
        pcnt_q   <= pcnt_d;
        hcnt_q   <= hcnt_d;
        period_q <= period_d;
        high_q   <= high_d;
      end
    end
  end

  // read mux; channels beyond CHANNEL_NUM fall through to zero
  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (wb_adr_i[3:1] == 3'(c)) begin
        rdata[31]          = valid_v[c];
        rdata[30]          = ovf_v[c];
        rdata[BIT_NUM-1:0] = wb_adr_i[0] ? period_v[c] : high_v[c];
      end
    end
  end

  // bus response: one-cycle ack for every strobe, data registered alongside
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb_we_i) ? rdata : '0;
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic irq_q;
  assign irq = irq_q;

  // interrupt follows any pending valid measurement one cycle later
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_q <= 1'b0;
    else            irq_q <= |valid_v;
  end
`endif

endmodule

// File: tb/tb_wb_pwm_capture.sv
`timescale 1ns/1ps
module tb_wb_pwm_capture;
  localparam int BIT_NUM     = 8;
  localparam int CHANNEL_NUM = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]             adr = '0;
  logic [31:0]            wdat = '0;
  logic [31:0]            dat_o;
  logic                   ack, stall;
  logic [CHANNEL_NUM-1:0] pwm_in;
`ifdef PWM_CAPTURE_IRQ_EN
  logic                   irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // waveform generator state: mode 0 = static level, 1 = periodic
  int   mode [CHANNEL_NUM] = '{default: 0};
  logic lvl  [CHANNEL_NUM] = '{default: 1'b0};
  int   hi   [CHANNEL_NUM] = '{default: 1};
  int   lo   [CHANNEL_NUM] = '{default: 1};
  int   ph   [CHANNEL_NUM] = '{default: 0};

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl [12];

  wb_pwm_capture #(.BIT_NUM(BIT_NUM), .CHANNEL_NUM(CHANNEL_NUM)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_stall_o(stall),
    .pwm_in    (pwm_in)
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // pins change on the falling edge, away from the sampling edge
  initial begin
    pwm_in = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (mode[c] == 1) begin
          pwm_in[c] = (ph[c] < hi[c]);
          ph[c] = (ph[c] + 1) % (hi[c] + lo[c]);
        end else begin
          pwm_in[c] = lvl[c];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pwm(input int c, input int h, input int l);
    hi[c] = h; lo[c] = l; ph[c] = 0; mode[c] = 1;
  endtask

  task automatic stop_all();
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      mode[c] = 0; lvl[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    stop_all();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  // one request, checked one cycle later
  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string name);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    tick(1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({name, "_ack"}, {31'd0, ack}, 32'd1);
    check(name, dat_o, exp);
  endtask

  // hold a high-word read until a valid flag appears, bounded
  task automatic poll_valid(input logic [3:0] a, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (ack && dat_o[31]) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int c, h, l;
    logic [31:0] e_hi, e_per;

    tbl[0]  = '{1'b0, 4'd0,  32'h0,        32'h8000_0003, "tb_hi0"};
    tbl[1]  = '{1'b0, 4'd2,  32'h0,        32'h8000_0002, "tb_hi1"};
    tbl[2]  = '{1'b1, 4'd1,  32'hFFFF_FFFF, 32'h0000_0000, "tb_wr1"};
    tbl[3]  = '{1'b0, 4'd1,  32'h0,        32'h8000_0008, "tb_per0"};
    tbl[4]  = '{1'b0, 4'd1,  32'h0,        32'h0000_0008, "tb_per0_clr"};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,        32'h0000_0003, "tb_hi0_clr"};
    tbl[6]  = '{1'b0, 4'd14, 32'h0,        32'h0000_0000, "tb_adr14"};
    tbl[7]  = '{1'b0, 4'd6,  32'h0,        32'h0000_0000, "tb_adr6"};
    tbl[8]  = '{1'b0, 4'd3,  32'h0,        32'h8000_0006, "tb_per1"};
    tbl[9]  = '{1'b1, 4'd3,  32'h1234_5678, 32'h0000_0000, "tb_wr3"};
    tbl[10] = '{1'b0, 4'd3,  32'h0,        32'h0000_0006, "tb_per1_clr"};
    tbl[11] = '{1'b0, 4'd2,  32'h0,        32'h0000_0002, "tb_hi1_clr"};

    // reset state
    tick(2);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
`ifdef PWM_CAPTURE_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    rst_n = 1'b1;
    tick(1);

    // table: ch0 3/5, ch1 2/4, then stopped and read
    set_pwm(0, 3, 5);
    set_pwm(1, 2, 4);
    tick(45);
    stop_all();
    tick(10);
    for (int i = 0; i < 12; i++)
      xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, tbl[i].exp, tbl[i].name);
`ifdef PWM_CAPTURE_IRQ_EN
    tick(1);
    check("tb_irq_clear", {31'd0, irq}, 32'd0);
`endif

    // back-to-back strobes 1,0,3
    do_reset();
    set_pwm(0, 3, 5);
    set_pwm(1, 2, 4);
    tick(45);
    stop_all();
    tick(10);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd1;
    check("b2b_stall0", {31'd0, stall}, 32'd0);
    tick(1);
    check("b2b_ack1", {31'd0, ack}, 32'd1);
    check("b2b_dat1", dat_o, 32'h8000_0008);
    adr = 4'd0;
    tick(1);
    check("b2b_ack0", {31'd0, ack}, 32'd1);
    check("b2b_dat0", dat_o, 32'h0000_0003);
    check("b2b_stall1", {31'd0, stall}, 32'd0);
    adr = 4'd3;
    tick(1);
    check("b2b_ack3", {31'd0, ack}, 32'd1);
    check("b2b_dat3", dat_o, 32'h8000_0006);
    cyc = 1'b0; stb = 1'b0;
    tick(1);
    check("b2b_ack_end", {31'd0, ack}, 32'd0);

    // constant high on ch1 -> overflow with full-scale high and period
    do_reset();
    lvl[1] = 1'b1;
    poll_valid(4'd2, 300, "to_hi_seen");
    xfer(1'b0, 4'd2, 32'h0, 32'hC000_00FF, "to_hi_high");
    xfer(1'b0, 4'd3, 32'h0, 32'hC000_00FF, "to_hi_period");

    // constant low on ch1 -> overflow with zero high time
    do_reset();
    poll_valid(4'd2, 300, "to_lo_seen");
    xfer(1'b0, 4'd2, 32'h0, 32'hC000_0000, "to_lo_high");
    xfer(1'b0, 4'd3, 32'h0, 32'hC000_00FF, "to_lo_period");

    // period read sampled in the same cycle as a latch
    do_reset();
    lvl[0] = 1'b1; tick(3); lvl[0] = 1'b0; tick(5);
    lvl[0] = 1'b1; tick(3); lvl[0] = 1'b0; tick(7);
    lvl[0] = 1'b1;
    tick(2);
    xfer(1'b0, 4'd1, 32'h0, 32'h8000_0008, "col_old");
    xfer(1'b0, 4'd1, 32'h0, 32'h8000_000A, "col_new");
    xfer(1'b0, 4'd1, 32'h0, 32'h0000_000A, "col_clr");

    // asynchronous reset mid-period with a response on the bus
    do_reset();
    set_pwm(0, 3, 5);
    tick(20);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd1;
    tick(1);
    cyc = 1'b0; stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_ack", {31'd0, ack}, 32'd0);
    check("ar_dat", dat_o, 32'd0);
`ifdef PWM_CAPTURE_IRQ_EN
    check("ar_irq", {31'd0, irq}, 32'd0);
`endif
    stop_all();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    lvl[0] = 1'b1; tick(3); lvl[0] = 1'b0;
    xfer(1'b0, 4'd0, 32'h0, 32'h0000_0000, "ar_first_rise");
`ifdef PWM_CAPTURE_IRQ_EN
    check("ar_irq_armed", {31'd0, irq}, 32'd0);
`endif
    tick(4);
    lvl[0] = 1'b1;
    tick(3);
`ifdef PWM_CAPTURE_IRQ_EN
    check("ar_irq_lat", {31'd0, irq}, 32'd0);
`endif
    tick(1);
`ifdef PWM_CAPTURE_IRQ_EN
    check("ar_irq_set", {31'd0, irq}, 32'd1);
`endif
    xfer(1'b0, 4'd0, 32'h0, 32'h8000_0003, "ar_hi");
    xfer(1'b0, 4'd1, 32'h0, 32'h8000_0008, "ar_per");
`ifdef PWM_CAPTURE_IRQ_EN
    check("ar_irq_hold", {31'd0, irq}, 32'd1);
    tick(1);
    check("ar_irq_drop", {31'd0, irq}, 32'd0);
`endif

    // random periodic waveforms against the waveform definition
    for (int t = 0; t < 8; t++) begin
      c = $urandom_range(0, CHANNEL_NUM - 1);
      h = $urandom_range(1, 60);
      l = $urandom_range(1, 60);
      e_hi  = 32'h8000_0000 | 32'(h);
      e_per = 32'h8000_0000 | 32'(h + l);
      do_reset();
      set_pwm(c, h, l);
      tick(3 * (h + l) + 10);
      stop_all();
      tick(10);
      xfer(1'b0, 4'(2 * c),     32'h0, e_hi,  $sformatf("rnd%0d_hi_c%0d_h%0d_l%0d", t, c, h, l));
      xfer(1'b0, 4'(2 * c + 1), 32'h0, e_per, $sformatf("rnd%0d_per", t));
      xfer(1'b0, 4'(2 * c + 1), 32'h0, e_per & 32'h3FFF_FFFF, $sformatf("rnd%0d_per_clr", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
